jacobi_solver: RTL and testbench
================================

// Module: jacobi_solver
// PURPOSE
//  Sequential wrapper around the combinational jacobi sweep. Holds the NU-point grid in registers,
//  accepts an initial grid as a word stream, then applies one jacobi sweep per clock until an
//  iteration limit or tolerance is met. Finally streams the result out. Boundary points stay fixed.
// PARAMETERS
//  NU      10  grid points, including 2 boundary points (NU>=3)
//  WIDTH   8   bits per grid value, unsigned
//  EXPON   3   source term h2 = 1<<EXPON; passed to jacobi
//  ITW     16  width of iteration limit/counter
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous reset, active-high
//  load_valid  in   1      load_data valid
//  load_ready  out  1      block accepts a load word
//  load_data   in   WIDTH  grid word; index 0 first, index NU-1 last
//  start       in   1      single-cycle pulse; begins iterating (honoured only in S_WAIT)
//  n_iter      in   ITW    max sweeps; sampled on the start cycle
//  tol         in   WIDTH  convergence tolerance; sampled on the start cycle
//  busy        out  1      high in S_ITER
//  out_valid   out  1      out_data valid
//  out_ready   in   1      consumer accepts out_data
//  out_data    out  WIDTH  result word, index 0 first
//  iter_count  out  ITW    sweeps done in current/last run
//  converged   out  1      last run stopped on tolerance
// BEHAVIOUR
//  Reset (async, immediate): state=S_LOAD, all u[i]=0, load_idx=out_idx=0,
//   iter_count=0, converged=0; outputs load_ready=1, busy=0, out_valid=0, out_data=0.
//  FSM: S_LOAD -> S_WAIT -> S_ITER -> S_OUT -> S_LOAD.
//  S_LOAD: load_ready=1. On load_valid&&load_ready: u[load_idx]<=load_data, load_idx++.
//   The transfer with load_idx==NU-1 sets load_idx=0 and state=S_WAIT.
//  S_WAIT: load_ready=0. start latches n_iter/tol and clears iter_count and converged.
//   If n_iter==0 -> S_OUT (u unchanged, converged=0); else -> S_ITER. start outside S_WAIT: ignored.
//  S_ITER: busy=1. Each cycle u<=jacobi(u), i.e. interior u[i]<=(h2+u[i-1]+u[i+1])/2.
//   Each sum is truncated to WIDTH bits (mod 2^WIDTH) before the halving; endpoints are held.
//   Each cycle iter_count++. delta = max over interior i of |new[i]-old[i]| (unsigned, WIDTH bits).
//   Stop when delta<=tol or iter_count+1==n_iter; the stopping sweep is still written.
//   On stop: next state S_OUT, converged=(delta<=tol). If both conditions hold, converged=1.
//   Latency: k sweeps = k cycles in S_ITER. out_valid rises the cycle after the last sweep.
//  S_OUT: out_valid=1, out_data=u[out_idx]. On out_valid&&out_ready: out_idx++.
//   out_ready low: out_valid and out_data hold stable. The transfer at out_idx==NU-1 sets out_idx=0
//   and state=S_LOAD; out_valid is 0 the next cycle. out_data=0 whenever out_valid=0.
//   iter_count and converged hold until the next start.
//  Outside S_LOAD, load_valid is ignored and load_ready=0. Outside S_OUT, out_ready is ignored.
//  rst at any time (mid-load, mid-iteration, mid-drain) aborts the run and restores reset state.
// TESTING (NU=10, WIDTH=8, EXPON=3 => h2=8)
//  1 Load 10x0, start n_iter=1 tol=0 -> out 0,4,4,4,4,4,4,4,4,0; iter_count=1; converged=0.
//  2 Load fixed point u[i]=4i(9-i): 0,32,56,72,80,80,72,56,32,0; n_iter=100, tol=0
//    -> one busy cycle, iter_count=1, converged=1, output equals input.
//  3 Wrap: load 10x200, n_iter=1 -> interior (8+144)/2=76: out 200,76x8,200.
//  4 n_iter=0 -> no busy cycle, output equals loaded data, iter_count=0, converged=0.
//  5 out_ready toggled 1,0,0,1,... with load_valid gaps -> no word lost or duplicated, out_data
//    stable while stalled, start pulsed in S_LOAD/S_OUT has no effect.
//  6 Assert rst 3 cycles into S_ITER -> busy=0, out_valid=0, load_ready=1 immediately;
//    a fresh load/run then matches scenario 1.

Source files
------------

// File: rtl/jacobi_solver_if.sv
// Handshake bundle for the jacobi solver: load stream in, control, result stream out.
interface jacobi_solver_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ITW   = 16
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             start;
  logic [ITW-1:0]   n_iter;
  logic [WIDTH-1:0] tol;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [ITW-1:0]   iter_count;
  logic             converged;

  modport master (
    output load_valid, load_data, start, n_iter, tol, out_ready,
    input  load_ready, busy, out_valid, out_data, iter_count, converged
  );

  modport slave (
    input  load_valid, load_data, start, n_iter, tol, out_ready,
    output load_ready, busy, out_valid, out_data, iter_count, converged
  );
endinterface

// File: rtl/jacobi_solver.sv
// Registered NU-point grid: stream in, one jacobi sweep per clock until the iteration
// limit or tolerance is reached, then stream the grid out. Endpoints never change.
module jacobi_solver #(
  parameter int unsigned NU    = 10,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned EXPON = 3,
  parameter int unsigned ITW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  jacobi_solver_if.slave  bus
);

  localparam int unsigned IW = (NU > 1) ? $clog2(NU) : 1;
  localparam logic [WIDTH-1:0] H2 = WIDTH'(1 << EXPON);

  typedef enum logic [1:0] {S_LOAD, S_WAIT, S_ITER, S_OUT} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_u [NU];
  logic [IW-1:0]    r_load_idx;
  logic [IW-1:0]    r_out_idx;
  logic [ITW-1:0]   r_iter_count;
  logic [ITW-1:0]   r_n_iter;
  logic [WIDTH-1:0] r_tol;
  logic             r_converged;
  logic             r_load_ready;
  logic             r_busy;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;

  logic [WIDTH-1:0] w_next [NU];
  logic [WIDTH-1:0] w_diff [NU];
  logic [WIDTH-1:0] w_delta;
  logic             w_tol_met;
  logic             w_limit;

  // Endpoints are held; they contribute zero change to the sweep delta.
  assign w_next[0]    = r_u[0];
  assign w_next[NU-1] = r_u[NU-1];
  assign w_diff[0]    = '0;
  assign w_diff[NU-1] = '0;

  for (genvar gi = 1; gi < NU - 1; gi++) begin : g_pt
    logic [WIDTH-1:0] w_sum;
    assign w_sum       = H2 + r_u[gi-1] + r_u[gi+1];
    assign w_next[gi]  = {1'b0, w_sum[WIDTH-1:1]};
    assign w_diff[gi]  = (w_next[gi] >= r_u[gi]) ? (w_next[gi] - r_u[gi])
                                                 : (r_u[gi] - w_next[gi]);
  end

  always_comb begin
    w_delta = '0;
    for (int i = 0; i < NU; i++) begin
      if (w_diff[i] > w_delta) w_delta = w_diff[i];
    end
  end

  assign w_tol_met = (w_delta <= r_tol);
  assign w_limit   = (ITW'(r_iter_count + ITW'(1)) == r_n_iter);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_LOAD;
      for (int i = 0; i < NU; i++) r_u[i] <= '0;
      r_load_idx   <= '0;
      r_out_idx    <= '0;
      r_iter_count <= '0;
      r_n_iter     <= '0;
      r_tol        <= '0;
      r_converged  <= 1'b0;
      r_load_ready <= 1'b1;
      r_busy       <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (bus.load_valid) begin
            r_u[r_load_idx] <= bus.load_data;
            if (r_load_idx == IW'(NU - 1)) begin
              r_load_idx   <= '0;
              r_load_ready <= 1'b0;
              r_state      <= S_WAIT;
            end else begin
              r_load_idx <= r_load_idx + IW'(1);
            end
          end
        end
        S_WAIT: begin
          if (bus.start) begin
            r_n_iter     <= bus.n_iter;
            r_tol        <= bus.tol;
            r_iter_count <= '0;
            r_converged  <= 1'b0;
            r_out_idx    <= '0;
            if (bus.n_iter == '0) begin
              r_out_valid <= 1'b1;
              r_out_data  <= r_u[0];
              r_state     <= S_OUT;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_ITER;
            end
          end
        end
        S_ITER: begin
          for (int i = 0; i < NU; i++) r_u[i] <= w_next[i];
          r_iter_count <= r_iter_count + ITW'(1);
          if (w_tol_met || w_limit) begin
            r_converged <= w_tol_met;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_out_data  <= w_next[0];
            r_state     <= S_OUT;
          end
        end
        S_OUT: begin
          // out_valid is always high here, so out_ready alone completes a transfer.
          if (bus.out_ready) begin
            if (r_out_idx == IW'(NU - 1)) begin
              r_out_idx    <= '0;
              r_out_valid  <= 1'b0;
              r_out_data   <= '0;
              r_load_ready <= 1'b1;
              r_state      <= S_LOAD;
            end else begin
              r_out_idx  <= r_out_idx + IW'(1);
              r_out_data <= r_u[r_out_idx + IW'(1)];
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign bus.load_ready = r_load_ready;
  assign bus.busy       = r_busy;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.iter_count = r_iter_count;
  assign bus.converged  = r_converged;

endmodule

// File: tb/tb_jacobi_solver.sv
// Scoreboard bench for jacobi_solver: a behavioural sweep model queues the expected
// output words when a run is started; words are popped as the DUT hands them out.
module tb_jacobi_solver;

  localparam int NU    = 10;
  localparam int WIDTH = 8;
  localparam int ITW   = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jacobi_solver_if #(.WIDTH(WIDTH), .ITW(ITW)) bus ();

  jacobi_solver #(.NU(NU), .WIDTH(WIDTH), .EXPON(3), .ITW(ITW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  grid [NU];
  logic [7:0]  exp_q [$];
  int          exp_iter;
  bit          exp_conv;

  task automatic check(input string tag, input longint got, input longint want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask

  // Reference sweep on plain integers: sum mod 256, then integer halving.
  task automatic model(input int n, input int t);
    int m [NU];
    int nv [NU];
    int d, ad, cnt;
    bit conv;
    for (int i = 0; i < NU; i++) m[i] = int'(grid[i]);
    cnt  = 0;
    conv = 1'b0;
    while (cnt < n) begin
      d  = 0;
      nv = m;
      for (int i = 1; i < NU - 1; i++) begin
        nv[i] = ((8 + m[i-1] + m[i+1]) % 256) / 2;
        ad    = (nv[i] > m[i]) ? nv[i] - m[i] : m[i] - nv[i];
        if (ad > d) d = ad;
      end
      m = nv;
      cnt++;
      if (d <= t) begin
        conv = 1'b1;
        break;
      end
    end
    exp_q.delete();
    for (int i = 0; i < NU; i++) exp_q.push_back(8'(m[i]));
    exp_iter = cnt;
    exp_conv = conv;
  endtask

  task automatic load_grid(input bit gaps);
    int guard;
    for (int i = 0; i < NU; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        bus.load_valid = 1'b0;
        @(negedge clk);
      end
      bus.load_valid = 1'b1;
      bus.load_data  = grid[i];
      guard = 0;
      while (!bus.load_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 20) check("load_timeout", 0, 1);
      @(negedge clk);
    end
    bus.load_valid = 1'b0;
    bus.load_data  = 8'hA5;
    check("load_ready_in_wait", bus.load_ready, 0);
  endtask

  task automatic start_run(input int n, input int t);
    int cnt, guard;
    model(n, t);
    bus.n_iter = 16'(n);
    bus.tol    = 8'(t);
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.n_iter = 16'd3;
    bus.tol    = 8'd255;
    cnt   = 0;
    guard = 0;
    while (!bus.out_valid && guard < 2000) begin
      if (bus.busy) cnt++;
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) check("out_valid_timeout", 0, 1);
    check("busy_cycles", cnt, exp_iter);
    check("iter_count", bus.iter_count, exp_iter);
    check("converged", bus.converged, exp_conv);
    check("busy_low_in_out", bus.busy, 0);
  endtask

  task automatic drain(input bit stall);
    int k, guard;
    logic [7:0] held, w;
    bit was_stall;
    k = 0;
    guard = 0;
    was_stall = 1'b0;
    held = '0;
    while (exp_q.size() > 0 && guard < 200) begin
      bus.out_ready = stall ? (k % 3 == 0) : 1'b1;
      bus.start     = stall && (k == 4);
      k++;
      check("out_valid_high", bus.out_valid, 1);
      if (was_stall) check("stall_hold", bus.out_data, held);
      if (bus.out_ready) begin
        w = exp_q.pop_front();
        check("out_data", bus.out_data, w);
      end
      was_stall = !bus.out_ready;
      held      = bus.out_data;
      @(negedge clk);
      guard++;
    end
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    if (guard >= 200) check("drain_timeout", 0, 1);
    check("out_valid_after", bus.out_valid, 0);
    check("out_data_after", bus.out_data, 0);
    check("load_ready_after", bus.load_ready, 1);
    check("busy_after", bus.busy, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.start      = 1'b0;
    bus.n_iter     = '0;
    bus.tol        = '0;
    bus.out_ready  = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_load_ready", bus.load_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_iter_count", bus.iter_count, 0);
    check("rst_converged", bus.converged, 0);
    rst = 1'b0;
    @(negedge clk);

    // All-zero grid, single sweep
    for (int i = 0; i < NU; i++) grid[i] = 8'd0;
    load_grid(1'b0);
    start_run(1, 0);
    drain(1'b0);

    // Fixed point converges on the first sweep
    for (int i = 0; i < NU; i++) grid[i] = 8'(4 * i * (9 - i));
    load_grid(1'b0);
    start_run(100, 0);
    drain(1'b0);

    // Sum wraps modulo 256 before halving
    for (int i = 0; i < NU; i++) grid[i] = 8'd200;
    load_grid(1'b0);
    start_run(1, 0);
    drain(1'b0);

    // Zero iteration limit returns the loaded grid
    for (int i = 0; i < NU; i++) grid[i] = 8'($urandom_range(0, 255));
    load_grid(1'b0);
    start_run(0, 0);
    drain(1'b0);

    // Stalls, load gaps, stray start pulses and stray load words
    bus.start  = 1'b1;
    bus.n_iter = 16'd1;
    @(negedge clk);
    bus.start  = 1'b0;
    check("start_in_load_ready", bus.load_ready, 1);
    check("start_in_load_busy", bus.busy, 0);
    for (int i = 0; i < NU; i++) grid[i] = 8'($urandom_range(0, 255));
    load_grid(1'b1);
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hFF;
    repeat (2) @(negedge clk);
    bus.load_valid = 1'b0;
    start_run(6, 3);
    drain(1'b1);

    // Reset in the middle of iterating
    for (int i = 0; i < NU; i++) grid[i] = 8'd0;
    load_grid(1'b0);
    bus.n_iter = 16'd50;
    bus.tol    = 8'd0;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_before_rst", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_load_ready", bus.load_ready, 1);
    check("mid_rst_iter_count", bus.iter_count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load_grid(1'b0);
    start_run(1, 0);
    drain(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
